// File: rtl/rs_pkg.sv
// Shared types and constants for the issue station: the entry record, default widths, and ALU op codes.
// Entry fields are sized by the package default widths.
package rs_pkg;

  localparam int unsigned ROB_BITS_DEF = 4;
  localparam int unsigned OP_W_DEF     = 5;

  localparam logic [OP_W_DEF-1:0] ALU_ADD  = 5'd0;
  localparam logic [OP_W_DEF-1:0] ALU_SUB  = 5'd1;
  localparam logic [OP_W_DEF-1:0] ALU_AND  = 5'd2;
  localparam logic [OP_W_DEF-1:0] ALU_OR   = 5'd3;
  localparam logic [OP_W_DEF-1:0] ALU_XOR  = 5'd4;
  localparam logic [OP_W_DEF-1:0] ALU_SLL  = 5'd5;
  localparam logic [OP_W_DEF-1:0] ALU_SRL  = 5'd6;
  localparam logic [OP_W_DEF-1:0] ALU_SRA  = 5'd7;
  localparam logic [OP_W_DEF-1:0] ALU_SLT  = 5'd8;
  localparam logic [OP_W_DEF-1:0] ALU_SLTU = 5'd9;

  typedef struct packed {
    logic                    busy;
    logic [OP_W_DEF-1:0]     op;
    logic [31:0]             vj;
    logic [31:0]             vk;
    logic [ROB_BITS_DEF-1:0] qj;
    logic [ROB_BITS_DEF-1:0] qk;
    logic                    rj;
    logic                    rk;
    logic [ROB_BITS_DEF-1:0] dest;
    logic [31:0]             imm;
    logic [31:0]             pc;
  } rs_entry_t;

endpackage

// File: rtl/issue_station_if.sv
// Insert and dispatch handshake bundle for the issue station.
interface issue_station_if
  import rs_pkg::*;
#(
  parameter int unsigned ROB_BITS = ROB_BITS_DEF,
  parameter int unsigned OP_W     = OP_W_DEF
);
  logic                in_valid;
  logic                in_ready;
  logic [OP_W-1:0]     in_op;
  logic [ROB_BITS-1:0] in_dest;
  logic [31:0]         in_imm;
  logic [31:0]         in_pc;
  logic [31:0]         in_vj;
  logic [31:0]         in_vk;
  logic [ROB_BITS-1:0] in_qj;
  logic [ROB_BITS-1:0] in_qk;
  logic                in_rdj;
  logic                in_rdk;

  logic                out_valid;
  logic                out_ready;
  logic [OP_W-1:0]     out_op;
  logic [31:0]         out_vj;
  logic [31:0]         out_vk;
  logic [31:0]         out_imm;
  logic [31:0]         out_pc;
  logic [ROB_BITS-1:0] out_dest;

  modport master (
    output in_valid, in_op, in_dest, in_imm, in_pc, in_vj, in_vk, in_qj, in_qk, in_rdj, in_rdk,
    output out_ready,
    input  in_ready,
    input  out_valid, out_op, out_vj, out_vk, out_imm, out_pc, out_dest
  );

  modport slave (
    input  in_valid, in_op, in_dest, in_imm, in_pc, in_vj, in_vk, in_qj, in_qk, in_rdj, in_rdk,
    input  out_ready,
    output in_ready,
    output out_valid, out_op, out_vj, out_vk, out_imm, out_pc, out_dest
  );
endinterface

// File: rtl/rs_pick_lowest.sv
// Priority encoder: index of the lowest set request bit plus a found flag.
module rs_pick_lowest #(
  parameter  int unsigned N  = 16,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          found
);
  always_comb begin
    idx   = '0;
    found = |req;
    for (int unsigned i = N; i > 0; i--) begin
      if (req[i-1]) idx = IW'(i - 1);
    end
  end
endmodule

// File: rtl/issue_station.sv
// Reservation station: holds instructions until their operands arrive on the CDB, then dispatches the lowest ready entry.
// Optional same-cycle CDB bypass on insert is enabled by defining RS_CDB_BYPASS_EN.
module issue_station
  import rs_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ROB_BITS  = ROB_BITS_DEF,
  parameter int unsigned CDB_PORTS = 2,
  parameter int unsigned OP_W      = OP_W_DEF
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          rdy_in,
  input  logic                          flush_in,
  issue_station_if.slave                bus,
  input  logic [CDB_PORTS-1:0]          cdb_valid,
  input  logic [CDB_PORTS*ROB_BITS-1:0] cdb_tag,
  input  logic [CDB_PORTS*32-1:0]       cdb_value,
  output logic [$clog2(DEPTH+1)-1:0]    count
);
  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  rs_entry_t           ent_q [DEPTH];
  rs_entry_t           ent_d [DEPTH];
  rs_entry_t           new_ent;
  logic [CW-1:0]       count_q, count_d;
  logic                out_valid_q, out_valid_d;
  logic [OP_W-1:0]     out_op_q, out_op_d;
  logic [31:0]         out_vj_q, out_vj_d, out_vk_q, out_vk_d;
  logic [31:0]         out_imm_q, out_imm_d, out_pc_q, out_pc_d;
  logic [ROB_BITS-1:0] out_dest_q, out_dest_d;

  logic [ROB_BITS-1:0] ctag [CDB_PORTS];
  logic [31:0]         cval [CDB_PORTS];
  logic [DEPTH-1:0]    free_v, elig_v;
  logic [IW-1:0]       free_idx, elig_idx;
  logic                free_found, elig_found;
  logic                ins, disp;

  always_comb begin
    for (int unsigned p = 0; p < CDB_PORTS; p++) begin
      ctag[p] = cdb_tag[p*ROB_BITS +: ROB_BITS];
      cval[p] = cdb_value[p*32 +: 32];
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      free_v[i] = ~ent_q[i].busy;
      elig_v[i] = ent_q[i].busy & ent_q[i].rj & ent_q[i].rk;
    end
  end

  rs_pick_lowest #(.N(DEPTH)) u_free_pick (.req(free_v), .idx(free_idx), .found(free_found));
  rs_pick_lowest #(.N(DEPTH)) u_elig_pick (.req(elig_v), .idx(elig_idx), .found(elig_found));

  assign bus.in_ready = free_found;

  // Incoming entry; ports are walked high to low so the lowest matching port wins.
  always_comb begin
    new_ent      = '0;
    new_ent.busy = 1'b1;
    new_ent.op   = OP_W_DEF'(bus.in_op);
    new_ent.vj   = bus.in_vj;
    new_ent.vk   = bus.in_vk;
    new_ent.qj   = ROB_BITS_DEF'(bus.in_qj);
    new_ent.qk   = ROB_BITS_DEF'(bus.in_qk);
    new_ent.rj   = bus.in_rdj;
    new_ent.rk   = bus.in_rdk;
    new_ent.dest = ROB_BITS_DEF'(bus.in_dest);
    new_ent.imm  = bus.in_imm;
    new_ent.pc   = bus.in_pc;
`ifdef RS_CDB_BYPASS_EN
    for (int unsigned p = CDB_PORTS; p > 0; p--) begin
      if (cdb_valid[p-1] && !bus.in_rdj && bus.in_qj == ctag[p-1]) begin
        new_ent.vj = cval[p-1];
        new_ent.rj = 1'b1;
      end
      if (cdb_valid[p-1] && !bus.in_rdk && bus.in_qk == ctag[p-1]) begin
        new_ent.vk = cval[p-1];
        new_ent.rk = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    ent_d       = ent_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_op_d    = out_op_q;
    out_vj_d    = out_vj_q;
    out_vk_d    = out_vk_q;
    out_imm_d   = out_imm_q;
    out_pc_d    = out_pc_q;
    out_dest_d  = out_dest_q;
    ins         = 1'b0;
    disp        = 1'b0;
    if (flush_in) begin
      for (int unsigned i = 0; i < DEPTH; i++) ent_d[i].busy = 1'b0;
      out_valid_d = 1'b0;
      count_d     = '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        for (int unsigned p = CDB_PORTS; p > 0; p--) begin
          if (ent_q[i].busy && cdb_valid[p-1]) begin
            if (!ent_q[i].rj && ent_q[i].qj == ROB_BITS_DEF'(ctag[p-1])) begin
              ent_d[i].vj = cval[p-1];
              ent_d[i].rj = 1'b1;
            end
            if (!ent_q[i].rk && ent_q[i].qk == ROB_BITS_DEF'(ctag[p-1])) begin
              ent_d[i].vk = cval[p-1];
              ent_d[i].rk = 1'b1;
            end
          end
        end
      end
      if (!out_valid_q || bus.out_ready) begin
        out_valid_d = elig_found;
        if (elig_found) begin
          disp                 = 1'b1;
          out_op_d             = OP_W'(ent_q[elig_idx].op);
          out_vj_d             = ent_q[elig_idx].vj;
          out_vk_d             = ent_q[elig_idx].vk;
          out_imm_d            = ent_q[elig_idx].imm;
          out_pc_d             = ent_q[elig_idx].pc;
          out_dest_d           = ROB_BITS'(ent_q[elig_idx].dest);
          ent_d[elig_idx].busy = 1'b0;
        end
      end
      // The free slot is never the dispatched one, so insert cannot collide with dispatch.
      if (bus.in_valid && free_found) begin
        ins             = 1'b1;
        ent_d[free_idx] = new_ent;
      end
      count_d = count_q + CW'(ins) - CW'(disp);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_op_q    <= '0;
      out_vj_q    <= '0;
      out_vk_q    <= '0;
      out_imm_q   <= '0;
      out_pc_q    <= '0;
      out_dest_q  <= '0;
    end else if (rdy_in) begin
      ent_q       <= ent_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_op_q    <= out_op_d;
      out_vj_q    <= out_vj_d;
      out_vk_q    <= out_vk_d;
      out_imm_q   <= out_imm_d;
      out_pc_q    <= out_pc_d;
      out_dest_q  <= out_dest_d;
    end
  end

  assign count         = count_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_op    = out_op_q;
  assign bus.out_vj    = out_vj_q;
  assign bus.out_vk    = out_vk_q;
  assign bus.out_imm   = out_imm_q;
  assign bus.out_pc    = out_pc_q;
  assign bus.out_dest  = out_dest_q;

endmodule
